// File: rtl/wreg_pkg.sv
// Shared definitions for the write-register tracking / forwarding slice.
//   AWIDTH     : register-address width (32 architectural registers)
//   FWD_*      : operand source select encodings driven to the EX operand muxes
//   stage_t    : one pipeline stage record {wreg, regwrite}
package wreg_pkg;

    localparam int unsigned AWIDTH = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic [AWIDTH-1:0] wreg;
        logic              regwrite;
    } stage_t;

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one EX source operand.
//   src          : EX source register address
//   mem_wreg/mem_regwrite : producer held in the MEM stage
//   wb_wreg/wb_regwrite   : producer held in the WB stage
//   sel          : FWD_MEM, FWD_WB or FWD_RF
module fwd_select
    import wreg_pkg::*;
(
    input  logic [AWIDTH-1:0] src,
    input  logic [AWIDTH-1:0] mem_wreg,
    input  logic              mem_regwrite,
    input  logic [AWIDTH-1:0] wb_wreg,
    input  logic              wb_regwrite,
    output logic [1:0]        sel
);

    // MEM is checked first: it holds the youngest producer of src.
    // $0 never carries regwrite=1 in the stage registers, so no zero check here.
    always_comb begin
        sel = FWD_RF;
        if (mem_regwrite && (mem_wreg == src)) begin
            sel = FWD_MEM;
        end else if (wb_regwrite && (wb_wreg == src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/wreg_track_fwd.sv
// Carries the selected destination register and its write enable from EX
// through MEM and WB, and derives operand forwarding selects and the
// load-use stall request.
//   clk, rst              : clock, asynchronous active-high reset
//   ex_wreg, ex_regwrite  : destination and write enable of the EX instruction
//   ex_memread            : EX instruction is a load
//   ex_rs, ex_rt          : EX source addresses (forwarding)
//   id_rs, id_rt          : ID source addresses (load-use check)
//   hold, flush           : pipeline freeze / bubble the EX instruction
//   mem_*, wb_*           : stage register contents; wb_* feeds the RF write port
//   fwd_a, fwd_b          : operand A/B source select
//   load_use_stall        : stall IF/ID and insert an EX bubble
module wreg_track_fwd
    import wreg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] ex_wreg,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [AWIDTH-1:0] ex_rs,
    input  logic [AWIDTH-1:0] ex_rt,
    input  logic [AWIDTH-1:0] id_rs,
    input  logic [AWIDTH-1:0] id_rt,
    input  logic              hold,
    input  logic              flush,
    output logic [AWIDTH-1:0] mem_wreg,
    output logic              mem_regwrite,
    output logic [AWIDTH-1:0] wb_wreg,
    output logic              wb_regwrite,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              load_use_stall
);

    stage_t mem_q;
    stage_t wb_q;
    logic   ex_wreg_nz;
    logic   ex_we;

    assign ex_wreg_nz = (ex_wreg != '0);
    // A write to $0 is dropped at capture, so downstream logic never sees it.
    assign ex_we      = ex_regwrite & ex_wreg_nz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!hold) begin
            mem_q.wreg     <= ex_wreg;
            mem_q.regwrite <= ex_we & ~flush;
            wb_q           <= mem_q;
        end
    end

    assign mem_wreg     = mem_q.wreg;
    assign mem_regwrite = mem_q.regwrite;
    assign wb_wreg      = wb_q.wreg;
    assign wb_regwrite  = wb_q.regwrite;

    fwd_select u_fwd_a (
        .src          (ex_rs),
        .mem_wreg     (mem_q.wreg),
        .mem_regwrite (mem_q.regwrite),
        .wb_wreg      (wb_q.wreg),
        .wb_regwrite  (wb_q.regwrite),
        .sel          (fwd_a)
    );

    fwd_select u_fwd_b (
        .src          (ex_rt),
        .mem_wreg     (mem_q.wreg),
        .mem_regwrite (mem_q.regwrite),
        .wb_wreg      (wb_q.wreg),
        .wb_regwrite  (wb_q.regwrite),
        .sel          (fwd_b)
    );

    // Stalling here keeps any consumer out of EX while its load sits in MEM,
    // which is why MEM forwarding needs no load qualification.
    assign load_use_stall = ex_memread & ex_regwrite & ex_wreg_nz &
                            ((ex_wreg == id_rs) | (ex_wreg == id_rt));

endmodule

// File: tb/tb_wreg_track_fwd.sv
module tb_wreg_track_fwd;
    import wreg_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [AWIDTH-1:0] ex_wreg, ex_rs, ex_rt, id_rs, id_rt;
    logic              ex_regwrite, ex_memread, hold, flush;
    logic [AWIDTH-1:0] mem_wreg, wb_wreg;
    logic              mem_regwrite, wb_regwrite;
    logic [1:0]        fwd_a, fwd_b;
    logic              load_use_stall;

    wreg_track_fwd dut (
        .clk            (clk),
        .rst            (rst),
        .ex_wreg        (ex_wreg),
        .ex_regwrite    (ex_regwrite),
        .ex_memread     (ex_memread),
        .ex_rs          (ex_rs),
        .ex_rt          (ex_rt),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .hold           (hold),
        .flush          (flush),
        .mem_wreg       (mem_wreg),
        .mem_regwrite   (mem_regwrite),
        .wb_wreg        (wb_wreg),
        .wb_regwrite    (wb_regwrite),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .load_use_stall (load_use_stall)
    );

    always #5 clk = ~clk;

    // Reference model: history of instructions that actually advanced out of
    // EX since reset, newest at the back. Entry 0-from-back is in MEM, 1 is in WB.
    typedef struct {
        logic [AWIDTH-1:0] a;
        logic              we;
    } rec_t;
    rec_t hist[$];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t stage_m(input int unsigned age);
        rec_t r;
        r.a  = '0;
        r.we = 1'b0;
        if (hist.size() > age) r = hist[hist.size() - 1 - age];
        return r;
    endfunction

    // Youngest in-flight writer of src wins; age 0 is MEM, age 1 is WB.
    function automatic logic [1:0] fwd_m(input logic [AWIDTH-1:0] src);
        for (int age = 0; age < 2; age++) begin
            rec_t r = stage_m(age);
            if (r.we && r.a == src && src != '0) return (age == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic logic stall_m();
        return ex_memread && ex_regwrite && ex_wreg != 0 &&
               (ex_wreg == id_rs || ex_wreg == id_rt);
    endfunction

    task automatic check_all();
        rec_t m, w;
        #1;
        m = stage_m(0);
        w = stage_m(1);
        chk("mem_wreg",       8'(mem_wreg),       8'(m.a));
        chk("mem_regwrite",   8'(mem_regwrite),   8'(m.we));
        chk("wb_wreg",        8'(wb_wreg),        8'(w.a));
        chk("wb_regwrite",    8'(wb_regwrite),    8'(w.we));
        chk("fwd_a",          8'(fwd_a),          8'(fwd_m(ex_rs)));
        chk("fwd_b",          8'(fwd_b),          8'(fwd_m(ex_rt)));
        chk("load_use_stall", 8'(load_use_stall), 8'(stall_m()));
    endtask

    task automatic drive(input logic [AWIDTH-1:0] wr, input logic rw, input logic mr,
                         input logic [AWIDTH-1:0] rs, input logic [AWIDTH-1:0] rt,
                         input logic [AWIDTH-1:0] irs, input logic [AWIDTH-1:0] irt,
                         input logic h, input logic f);
        ex_wreg = wr; ex_regwrite = rw; ex_memread = mr;
        ex_rs = rs; ex_rt = rt; id_rs = irs; id_rt = irt;
        hold = h; flush = f;
        check_all();
    endtask

    task automatic set_rst(input logic r);
        rst = r;
        if (r) hist.delete();
        check_all();
    endtask

    task automatic tick();
        rec_t r;
        @(posedge clk);
        if (!rst && !hold) begin
            r.a  = ex_wreg;
            r.we = ex_regwrite && !flush && (ex_wreg != 0);
            hist.push_back(r);
            if (hist.size() > 2) void'(hist.pop_front());
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        hist.delete();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_fwd_a", 8'(fwd_a), 8'h0);
        tick();
        set_rst(1'b0);
        tick();

        // Back-to-back dependency
        drive(8, 1, 0, 1, 2, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 8, 8, 0, 0, 0, 0);
        chk("b2b_fwd_a_mem", 8'(fwd_a), 8'h2);
        chk("b2b_fwd_b_mem", 8'(fwd_b), 8'h2);
        tick();
        drive(1, 0, 0, 8, 3, 0, 0, 0, 0);
        chk("b2b_fwd_a_wb", 8'(fwd_a), 8'h1);

        // MEM and WB both hold $5
        drive(5, 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        drive(2, 0, 0, 1, 5, 0, 0, 0, 0);
        chk("prio_fwd_b", 8'(fwd_b), 8'h2);
        chk("prio_wb_rw", 8'(wb_regwrite), 8'h1);

        // Write to $0 is never recorded or forwarded
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("zero_mem_rw", 8'(mem_regwrite), 8'h0);
        chk("zero_fwd_a",  8'(fwd_a),        8'h0);

        // Load-use
        drive(9, 1, 1, 0, 0, 1, 9, 0, 0);
        chk("lu_hit", 8'(load_use_stall), 8'h1);
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("lu_zero", 8'(load_use_stall), 8'h0);
        drive(9, 1, 1, 0, 0, 3, 3, 0, 0);
        chk("lu_miss", 8'(load_use_stall), 8'h0);

        // Flush bubbles the captured instruction but keeps its address
        drive(4, 1, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(4, 1, 0, 4, 4, 0, 0, 0, 0);
        chk("flush_mem_rw",   8'(mem_regwrite), 8'h0);
        chk("flush_mem_wreg", 8'(mem_wreg),     8'h4);
        chk("flush_fwd_a",    8'(fwd_a),        8'h0);
        tick();
        // MEM={4,1}, WB={4,0}; hold with a pending flush for three cycles
        drive(11, 1, 0, 4, 11, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all();
            chk("hold_mem_wreg", 8'(mem_wreg),     8'h4);
            chk("hold_mem_rw",   8'(mem_regwrite), 8'h1);
            chk("hold_wb_rw",    8'(wb_regwrite),  8'h0);
        end
        drive(11, 1, 0, 4, 11, 0, 0, 0, 0);
        tick();
        check_all();
        chk("release_mem_wreg", 8'(mem_wreg), 8'hb);
        chk("release_wb_wreg",  8'(wb_wreg),  8'h4);
        chk("release_fwd_b",    8'(fwd_b),    8'h2);

        // Reset mid-run with MEM={7,1}
        drive(7, 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(7, 1, 0, 7, 7, 0, 0, 0, 0);
        chk("pre_rst_fwd_a", 8'(fwd_a), 8'h2);
        set_rst(1'b1);
        chk("async_mem_rw", 8'(mem_regwrite), 8'h0);
        chk("async_mem_wr", 8'(mem_wreg),     8'h0);
        chk("async_fwd_a",  8'(fwd_a),        8'h0);
        tick();
        set_rst(1'b0);
        drive(1, 0, 0, 7, 7, 0, 0, 0, 0);
        chk("post_rst_fwd_a", 8'(fwd_a), 8'h0);
        tick();
        check_all();
        tick();
        check_all();

        // Randomised traffic over a small address range to provoke collisions
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) set_rst(1'b1);
            else if (rst) set_rst(1'b0);
            drive(AWIDTH'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 3) == 0),
                  AWIDTH'($urandom_range(0, 7)), AWIDTH'($urandom_range(0, 7)),
                  AWIDTH'($urandom_range(0, 7)), AWIDTH'($urandom_range(0, 7)),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
            tick();
            check_all();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wreg_track_fwd.md
# wreg_track_fwd

Carries the write-register address selected by the destination-register mux (rt/rd choice) from EX through MEM and WB, together with its write-enable. Drives the register-file write address and enable, and produces the operand forwarding selects and the load-use stall request for the pipeline. It sits directly downstream of the destination mux and upstream of the register-file write port and the ALU operand muxes.

## Interface
- AWIDTH, 5, register-address width (32 architectural registers)
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- ex_wreg  in  AWIDTH  destination address from the destination mux, EX stage
- ex_regwrite  in  1  EX instruction writes a register
- ex_memread  in  1  EX instruction is a load
- ex_rs, ex_rt  in  AWIDTH  source addresses of the EX instruction (forwarding)
- id_rs, id_rt  in  AWIDTH  source addresses of the ID instruction (hazard check)
- hold  in  1  global pipeline freeze
- flush  in  1  kill the EX instruction (converted to a bubble on capture)
- mem_wreg, wb_wreg  out  AWIDTH  registered destination addresses, MEM and WB stages
- mem_regwrite, wb_regwrite  out  1  registered write enables; wb_* drives the register-file write port
- fwd_a, fwd_b  out  2  operand A/B source select: 00 register file, 10 from MEM, 01 from WB
- load_use_stall  out  1  request to stall IF/ID and insert an EX bubble

## Operation
- Two stage registers, MEM and WB, each holding {wreg, regwrite}.
- Normal edge: MEM <= {ex_wreg, ex_regwrite}; WB <= MEM.
- Effective write enable: a regwrite to address 0 is captured as regwrite=0. $0 is never written and never forwarded.
- flush=1, hold=0: MEM captures {ex_wreg, 0}. WB advances normally.
- hold=1: both stages keep their values. flush is ignored while hold=1; the controller keeps flush asserted until hold drops.
- Precedence: rst > hold > flush > normal.
- Forwarding for operand A (B is identical, using ex_rt):
  - fwd_a=10 if mem_regwrite and mem_wreg==ex_rs.
  - Otherwise 01 if wb_regwrite and wb_wreg==ex_rs.
  - Otherwise 00.
  - MEM has priority over WB because it holds the youngest producer.
- load_use_stall = ex_memread & ex_regwrite & (ex_wreg!=0) & (ex_wreg==id_rs | ex_wreg==id_rt).
  - The stall guarantees that no consumer is ever in EX while its load is in MEM, so MEM forwarding needs no load qualification.
- load_use_stall and fwd_* are evaluated independently of hold and flush.

## Timing
- Reset values (asynchronous, immediate): mem_wreg=0, mem_regwrite=0, wb_wreg=0, wb_regwrite=0. With these values fwd_a=fwd_b=00, and load_use_stall follows its inputs only.
- Latency: ex_wreg appears on mem_wreg 1 cycle after capture and on wb_wreg 2 cycles after capture.
- fwd_a, fwd_b and load_use_stall are combinational from the stage registers and current inputs, with no added cycle. They must settle within the same cycle for the EX operand muxes.
- Reset released mid-stream: the pipeline restarts empty. No stale forward may occur in the first two cycles.
- Simultaneous MEM and WB match on the same address: select 10.
- Both operands matching the same producer: both selects indicate that producer.

## Structure
- Shared package wreg_pkg:
  - AWIDTH.
  - Forwarding select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - The stage-record typedef {wreg, regwrite}.
- Sub-module fwd_select, instantiated twice (operand A and B). It takes src, mem_wreg, mem_regwrite, wb_wreg and wb_regwrite, and returns the 2-bit select.
- Stage registers and hazard logic live in the top module.

## Test plan
- Reset mid-run: assert rst with MEM={7,1}. Required: all outputs 0 immediately, asynchronously. After release, ex_rs=7 gives fwd_a=00.
- Back-to-back dependency: cycle n has ex_wreg=8, ex_regwrite=1. Cycle n+1 has ex_rs=8, ex_rt=8. Required: fwd_a=fwd_b=10. Cycle n+2 has ex_rs=8. Required: fwd_a=01.
- Priority and $0 handling:
  - MEM={5,1} and WB={5,1}, ex_rt=5. Required: fwd_b=10.
  - Capture ex_wreg=0 with ex_regwrite=1. Required: mem_regwrite=0 and fwd remains 00 for ex_rs=0.
- Load-use: ex_memread=1, ex_regwrite=1, ex_wreg=9, id_rt=9. Required: load_use_stall=1. Same inputs with ex_wreg=0 or id_rs=id_rt=3. Required: load_use_stall=0.
- Flush and hold:
  - flush=1 with ex_wreg=4, ex_regwrite=1. Required: next mem_regwrite=0 and mem_wreg=4.
  - hold=1 for 3 cycles. Required: MEM/WB unchanged, and a simultaneous flush has no effect.
  - hold drops. Required: stages advance on the next edge.
